// File: rtl/pic_stream_fifo.sv
// pic_stream_fifo: ADC sample FIFO drained by a PIC PMP request handshake.
// Samples are pushed on qualified decimation strobes; each synchronised
// rising edge of pmp_dreq pops one sample onto the registered pmp_d bus.
// Optional feature macro: PIC_STREAM_OVF_CNT_EN adds a saturating
// dropped-sample counter on port ovf_count.
module pic_stream_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        adc_data,
    input  logic                     decim_stb,
    input  logic                     capture_en,
    input  logic                     pmp_dreq,
    output logic [DATA_W-1:0]        pmp_d,
    output logic                     pmp_dvalid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     empty,
    output logic                     ovf,
    input  logic                     ovf_clr
`ifdef PIC_STREAM_OVF_CNT_EN
    ,
    output logic [15:0]              ovf_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic                empty_q, ovf_q;
    logic [DATA_W-1:0]   pmp_d_q, pmp_d_d;
    logic                dvalid_q, dvalid_d;

    // Synchroniser, edge-detect history and registered edge pulses
    logic                dreq_s1_q, dreq_s2_q, dreq_s3_q;
    logic                rise_q, fall_q;
    // Marks when dreq_s3_q holds a real sample rather than its reset value,
    // so a request held high through reset is not mistaken for a new rise.
    logic [2:0]          prime_q;

    logic                full_c, qual_c, push_c, pop_c, drop_c;

    assign full_c = (level_q == LW'(DEPTH));
    assign qual_c = decim_stb & capture_en;
    assign push_c = qual_c & (~full_c | pop_c);
    assign drop_c = qual_c & full_c & ~pop_c;

    assign pmp_d      = pmp_d_q;
    assign pmp_dvalid = dvalid_q;
    assign fifo_level = level_q;
    assign empty      = empty_q;
    assign ovf        = ovf_q;

    // Output FSM next state: pop the head on a rise in IDLE, release on a fall in ACK
    always_comb begin
        state_d  = state_q;
        pop_c    = 1'b0;
        pmp_d_d  = pmp_d_q;
        dvalid_d = dvalid_q;
        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    state_d = ACK;
                    if (!empty_q) begin
                        pop_c    = 1'b1;
                        pmp_d_d  = mem_q[rd_ptr_q];
                        dvalid_d = 1'b1;
                    end
                end
            end
            ACK: begin
                if (fall_q) begin
                    state_d  = IDLE;
                    dvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy after this edge's push and pop
    always_comb begin
        level_d = level_q;
        if (push_c && !pop_c) begin
            level_d = level_q + LW'(1);
        end else if (pop_c && !push_c) begin
            level_d = level_q - LW'(1);
        end
    end

    // Sample storage; no reset needed since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= adc_data;
        end
    end

    // Control, status and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            pmp_d_q   <= '0;
            dvalid_q  <= 1'b0;
            dreq_s1_q <= 1'b0;
            dreq_s2_q <= 1'b0;
            dreq_s3_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            prime_q   <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            empty_q   <= (level_d == '0);
            pmp_d_q   <= pmp_d_d;
            dvalid_q  <= dvalid_d;
            dreq_s1_q <= pmp_dreq;
            dreq_s2_q <= dreq_s1_q;
            dreq_s3_q <= dreq_s2_q;
            prime_q   <= {prime_q[1:0], 1'b1};
            rise_q    <= prime_q[2] & dreq_s2_q & ~dreq_s3_q;
            fall_q    <= prime_q[2] & ~dreq_s2_q & dreq_s3_q;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // A new drop takes priority over a clear in the same cycle
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef PIC_STREAM_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    assign ovf_count = ovf_cnt_q;

    // Saturating dropped-sample counter; a drop beats a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (drop_c) begin
            if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            ovf_cnt_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pic_stream_fifo.sv
// Directed bench for pic_stream_fifo (DATA_W=8, DEPTH=16).
module tb_pic_stream_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LW     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] adc_data;
    logic              decim_stb;
    logic              capture_en;
    logic              pmp_dreq;
    logic              ovf_clr;
    logic [DATA_W-1:0] pmp_d;
    logic              pmp_dvalid;
    logic [LW-1:0]     fifo_level;
    logic              empty;
    logic              ovf;
`ifdef PIC_STREAM_OVF_CNT_EN
    logic [15:0]       ovf_count;
`endif

    always #5 clk = ~clk;

    pic_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_data   (adc_data),
        .decim_stb  (decim_stb),
        .capture_en (capture_en),
        .pmp_dreq   (pmp_dreq),
        .pmp_d      (pmp_d),
        .pmp_dvalid (pmp_dvalid),
        .fifo_level (fifo_level),
        .empty      (empty),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`ifdef PIC_STREAM_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    typedef struct {
        logic       stb;
        logic       en;
        logic       clr;
        logic [7:0] data;
        int         lvl;
        int         emp;
        int         ovf;
        int         cnt;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic stb, input logic en, input logic clr,
                                input logic [7:0] data, input int lvl, input int emp,
                                input int ov, input int cnt);
        vec_t v;
        v.stb = stb; v.en = en; v.clr = clr; v.data = data;
        v.lvl = lvl; v.emp = emp; v.ovf = ov; v.cnt = cnt;
        return v;
    endfunction

    // Apply each record for one edge, then compare status outputs
    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            decim_stb  = vecs[i].stb;
            capture_en = vecs[i].en;
            ovf_clr    = vecs[i].clr;
            adc_data   = vecs[i].data;
            tick();
            check($sformatf("%s[%0d].level", tag, i), 32'(fifo_level), vecs[i].lvl);
            check($sformatf("%s[%0d].empty", tag, i), 32'(empty), vecs[i].emp);
            check($sformatf("%s[%0d].ovf", tag, i), 32'(ovf), vecs[i].ovf);
`ifdef PIC_STREAM_OVF_CNT_EN
            check($sformatf("%s[%0d].ovf_count", tag, i), 32'(ovf_count), vecs[i].cnt);
`endif
        end
        decim_stb = 1'b0;
        ovf_clr   = 1'b0;
        vecs.delete();
    endtask

    task automatic push(input logic [7:0] d);
        decim_stb  = 1'b1;
        capture_en = 1'b1;
        adc_data   = d;
        tick();
        decim_stb  = 1'b0;
    endtask

    // Full request handshake: rise, expect data on the 4th edge, fall, expect release
    task automatic do_read(input logic [7:0] exp, input bit lat);
        pmp_dreq = 1'b1;
        tick(); tick(); tick();
        if (lat) check("latency_edge3_dvalid", 32'(pmp_dvalid), 0);
        tick();
        check("read_dvalid", 32'(pmp_dvalid), 1);
        check("read_data", 32'(pmp_d), 32'(exp));
        pmp_dreq = 1'b0;
        repeat (4) tick();
        check("release_dvalid", 32'(pmp_dvalid), 0);
    endtask

    initial begin
        rst = 1'b1; adc_data = '0; decim_stb = 1'b0; capture_en = 1'b0;
        pmp_dreq = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        check("rst_level", 32'(fifo_level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_dvalid", 32'(pmp_dvalid), 0);
        check("rst_pmp_d", 32'(pmp_d), 0);
        rst = 1'b0;
        tick(); tick(); tick();

        // Basic pushes, plus strobe/enable gating
        vecs.push_back(mk(1, 1, 0, 8'h11, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h22, 2, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h33, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'hEE, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'hEF, 3, 0, 0, 0));
        run_table("basic");

        do_read(8'h11, 1'b1);
        check("basic_level_after1", 32'(fifo_level), 2);
        do_read(8'h22, 1'b0);
        do_read(8'h33, 1'b0);
        check("basic_level_end", 32'(fifo_level), 0);
        check("basic_empty_end", 32'(empty), 1);

        // Request while empty: no data, no bypass of a later push
        pmp_dreq = 1'b1;
        repeat (4) tick();
        check("empty_req_dvalid", 32'(pmp_dvalid), 0);
        check("empty_req_pmp_d", 32'(pmp_d), 32'h33);
        push(8'h44);
        repeat (6) tick();
        check("empty_req_no_bypass_dvalid", 32'(pmp_dvalid), 0);
        check("empty_req_no_bypass_level", 32'(fifo_level), 1);
        pmp_dreq = 1'b0;
        repeat (4) tick();
        do_read(8'h44, 1'b0);
        check("empty_req_level_end", 32'(fifo_level), 0);

        // Overflow: 16 fill, 17th dropped, clear, set-wins-over-clear
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 1, 0, 8'(8'h80 + i), i + 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h90, 16, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'h00, 16, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h91, 16, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'h00, 16, 0, 0, 0));
        run_table("ovf");

        // Push and pop on the same edge while full
        pmp_dreq = 1'b1;
        tick(); tick(); tick();
        decim_stb = 1'b1; capture_en = 1'b1; adc_data = 8'hA5;
        tick();
        decim_stb = 1'b0;
        check("pushpop_level", 32'(fifo_level), 16);
        check("pushpop_ovf", 32'(ovf), 0);
        check("pushpop_dvalid", 32'(pmp_dvalid), 1);
        check("pushpop_data", 32'(pmp_d), 32'h80);
        pmp_dreq = 1'b0;
        repeat (4) tick();
        for (int i = 1; i < 16; i++) do_read(8'(8'h80 + i), 1'b0);
        do_read(8'hA5, 1'b0);
        check("pushpop_level_end", 32'(fifo_level), 0);
        check("pushpop_empty_end", 32'(empty), 1);

        // Reset with 5 stored entries while a request is held high
        for (int i = 0; i < 5; i++) push(8'(8'hB0 + i));
        check("prerst_level", 32'(fifo_level), 5);
        pmp_dreq = 1'b1;
        rst = 1'b1;
        tick();
        check("midrst_level", 32'(fifo_level), 0);
        check("midrst_empty", 32'(empty), 1);
        check("midrst_dvalid", 32'(pmp_dvalid), 0);
        check("midrst_pmp_d", 32'(pmp_d), 0);
        rst = 1'b0;
        repeat (6) tick();
        push(8'hC1);
        push(8'hC2);
        repeat (6) tick();
        check("postrst_no_read_dvalid", 32'(pmp_dvalid), 0);
        check("postrst_no_read_level", 32'(fifo_level), 2);
        pmp_dreq = 1'b0;
        repeat (4) tick();
        do_read(8'hC1, 1'b0);
        check("postrst_level", 32'(fifo_level), 1);
        do_read(8'hC2, 1'b0);

        // Stream 40 samples in batches of 10 so the pointers wrap repeatedly
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                logic [7:0] d;
                d = 8'(8'h01 + b * 10 + i);
                model_q.push_back(d);
                push(d);
            end
            check($sformatf("wrap_level_b%0d", b), 32'(fifo_level), 10);
            while (model_q.size() > 0) do_read(model_q.pop_front(), 1'b0);
        end
        check("wrap_empty_end", 32'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
